vsa_param_core: RTL and testbench

Parametrised successor of the 12-bit Very Simple Architecture, a non-pipelined 5-state processor core. It generalises data width, register count and PC width. New capabilities:
- instruction-fetch and data-memory wait-state handshakes
- sign-extended branch offsets (backward branches)
- a BNEZ opcode
- a HALT opcode
- a retire strobe for verification monitors

It sits between an instruction source and a data memory, and is used as a model-checking and simulation benchmark.

---
 rtl/vsa_param_pkg.sv | 55 +++++
 rtl/vsa_param_alu.sv | 50 +++++
 rtl/vsa_param_core.sv | 233 +++++++++++++++++++++++
 tb/tb_vsa_param_core.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsa_param_pkg.sv
// vsa_param_pkg
// Shared definitions for the parametrised VSA core:
//   - state_t : FSM state encoding (IF, ID, EX, MEM, WB, HLT)
//   - OP_*    : 3-bit opcodes
//   - FN_*    : 3-bit ALU function codes for the R-format ALU opcode
//   - zeroExtend / signExtend : extend the low 'width' bits of a 32-bit
//     value; callers size-cast the result to the width they need
//     (all widths used with these helpers must be <= 32).
package vsa_param_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_HLT = 3'd5
    } state_t;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_BEQZ = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SUBI = 3'd5;
    localparam logic [2:0] OP_BNEZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_SUB  = 3'd1;
    localparam logic [2:0] FN_AND  = 3'd2;
    localparam logic [2:0] FN_OR   = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd4;
    localparam logic [2:0] FN_NOTA = 3'd5;
    localparam logic [2:0] FN_SRL  = 3'd6;
    localparam logic [2:0] FN_SRA  = 3'd7;

    // Keep the low 'width' bits, clear everything above.
    function automatic logic [31:0] zeroExtend(input logic [31:0] value, input int width);
        logic [31:0] upper;
        upper = (width >= 32) ? 32'h0 : (32'hFFFF_FFFF << width);
        return value & ~upper;
    endfunction

    // Replicate bit 'width-1' into every bit above it.
    function automatic logic [31:0] signExtend(input logic [31:0] value, input int width);
        logic [31:0] upper;
        upper = (width >= 32) ? 32'h0 : (32'hFFFF_FFFF << width);
        if (((value >> (width - 1)) & 32'h1) != 32'h0) begin
            return value | upper;
        end
        return value & ~upper;
    endfunction

endpackage

// File: rtl/vsa_param_alu.sv
// vsa_param_alu
// Combinational execute-stage arithmetic for the VSA core.
// Ports:
//   opcode [3]    : instruction opcode (selects immediate add/sub or R-format op)
//   funct  [3]    : R-format function code, used only when opcode == OP_ALU
//   a, b   [DW]   : operand registers A and B
//   imm    [IMMW] : raw immediate field, zero-extended here
//   result [DW]   : ALUOutput candidate (modulo 2^DW, no flags)
// Branch targets are formed in the core because they need NPC.
module vsa_param_alu
    import vsa_param_pkg::*;
#(
    parameter int DW   = 8,
    parameter int IMMW = 5
) (
    input  logic [2:0]      opcode,
    input  logic [2:0]      funct,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [IMMW-1:0] imm,
    output logic [DW-1:0]   result
);

    logic [DW-1:0] immZext;

    assign immZext = DW'(zeroExtend(32'(imm), IMMW));

    always_comb begin
        // LW/SW/ADDI all want base + offset, so that is the default.
        result = a + immZext;
        unique case (opcode)
            OP_SUBI: result = a - immZext;
            OP_ALU: begin
                unique case (funct)
                    FN_ADD:  result = a + b;
                    FN_SUB:  result = a - b;
                    FN_AND:  result = a & b;
                    FN_OR:   result = a | b;
                    FN_XOR:  result = a ^ b;
                    FN_NOTA: result = ~a;
                    FN_SRL:  result = a >> 1;
                    FN_SRA:  result = {a[DW-1], a[DW-1:1]};
                    default: result = a + b;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vsa_param_core.sv
// vsa_param_core
// Non-pipelined multi-cycle VSA processor: IF -> ID -> EX -> MEM -> WB,
// plus an absorbing HLT state entered from ID on the HALT opcode.
// Ports:
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   pc           : instruction address (PCW bits)
//   inst_valid   : instruction bus valid, only sampled in IF
//   instruction  : instruction word (IW = 3*RW+6 bits)
//   mem_req, wr  : data access request / write qualifier (combinational from state)
//   mem_addr     : data address (ALUOutput register)
//   dataout      : store data (B register)
//   datain       : load data, captured on the acked MEM cycle of LW
//   mem_ack      : data access complete, only sampled in MEM for LW/SW
//   halted       : high while in HLT
//   retire       : one-cycle pulse in WB
module vsa_param_core
    import vsa_param_pkg::*;
#(
    parameter int  DW      = 8,
    parameter int  NREG    = 4,
    parameter int  PCW     = 6,
    parameter int  PC_STEP = 2,
    localparam int RW      = $clog2(NREG),
    localparam int IW      = 3 * RW + 6,
    localparam int IMMW    = RW + 3
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [PCW-1:0]  pc,
    input  logic            inst_valid,
    input  logic [IW-1:0]   instruction,
    output logic            mem_req,
    output logic            wr,
    output logic [DW-1:0]   mem_addr,
    output logic [DW-1:0]   dataout,
    input  logic [DW-1:0]   datain,
    input  logic            mem_ack,
    output logic            halted,
    output logic            retire
);

    localparam logic [PCW-1:0] PC_INC = PCW'(PC_STEP);

    state_t          stateReg;
    state_t          stateNext;

    logic [IW-1:0]   irReg;
    logic [PCW-1:0]  pcReg;
    logic [PCW-1:0]  npcReg;
    logic [DW-1:0]   aReg;
    logic [DW-1:0]   bReg;
    logic [DW-1:0]   aluOutReg;
    logic [DW-1:0]   lmdReg;
    logic            condReg;
    logic [DW-1:0]   regFile [NREG];

    // Instruction fields. The I-format destination occupies the same bits
    // as the R-format src2 field, so it is decoded as src2.
    logic [2:0]      opcode;
    logic [RW-1:0]   src1;
    logic [RW-1:0]   src2;
    logic [RW-1:0]   dstR;
    logic [2:0]      funct;
    logic [IMMW-1:0] imm;

    assign opcode = irReg[IW-1 -: 3];
    assign src1   = irReg[IW-4 -: RW];
    assign src2   = irReg[IW-4-RW -: RW];
    assign dstR   = irReg[IW-4-2*RW -: RW];
    assign funct  = irReg[2:0];
    assign imm    = irReg[IMMW-1:0];

    logic isMemOp;
    logic isBranch;
    logic memExit;

    assign isMemOp  = (opcode == OP_LW) || (opcode == OP_SW);
    assign isBranch = (opcode == OP_BEQZ) || (opcode == OP_BNEZ);
    // Non-memory opcodes spend exactly one cycle in MEM.
    assign memExit  = (stateReg == ST_MEM) && (!isMemOp || mem_ack);

    // R0 is hard-wired to zero on the read side.
    logic [DW-1:0] readA;
    logic [DW-1:0] readB;

    assign readA = (src1 == '0) ? '0 : regFile[src1];
    assign readB = (src2 == '0) ? '0 : regFile[src2];

    logic [DW-1:0]  aluResult;
    logic [PCW-1:0] branchTarget;

    vsa_param_alu #(
        .DW   (DW),
        .IMMW (IMMW)
    ) aluInst (
        .opcode (opcode),
        .funct  (funct),
        .a      (aReg),
        .b      (bReg),
        .imm    (imm),
        .result (aluResult)
    );

    // Word offset: sign-extended immediate doubled, wrapping at 2^PCW.
    assign branchTarget = npcReg + PCW'(signExtend(32'(imm), IMMW) << 1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= ST_IF;
        end else begin
            stateReg <= stateNext;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            ST_IF:   stateNext = inst_valid ? ST_ID : ST_IF;
            ST_ID:   stateNext = (opcode == OP_HALT) ? ST_HLT : ST_EX;
            ST_EX:   stateNext = ST_MEM;
            ST_MEM:  stateNext = memExit ? ST_WB : ST_MEM;
            ST_WB:   stateNext = ST_IF;
            ST_HLT:  stateNext = ST_HLT;
            default: stateNext = ST_IF;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded straight from the state register so an asynchronous reset
    // drops mem_req/wr without waiting for a clock edge.
    always_comb begin
        mem_req = 1'b0;
        wr      = 1'b0;
        halted  = 1'b0;
        retire  = 1'b0;
        unique case (stateReg)
            ST_MEM: begin
                mem_req = isMemOp;
                wr      = (opcode == OP_SW);
            end
            ST_WB:   retire = 1'b1;
            ST_HLT:  halted = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irReg     <= '0;
            pcReg     <= '0;
            npcReg    <= '0;
            aReg      <= '0;
            bReg      <= '0;
            aluOutReg <= '0;
            lmdReg    <= '0;
            condReg   <= 1'b0;
        end else begin
            unique case (stateReg)
                ST_IF: begin
                    if (inst_valid) begin
                        irReg  <= instruction;
                        npcReg <= pcReg + PC_INC;
                    end
                end
                ST_ID: begin
                    aReg <= readA;
                    bReg <= readB;
                end
                ST_EX: begin
                    aluOutReg <= isBranch ? DW'(branchTarget) : aluResult;
                    condReg   <= (opcode == OP_BEQZ) ? (aReg == '0) : (aReg != '0);
                end
                ST_MEM: begin
                    if ((opcode == OP_LW) && mem_ack) begin
                        lmdReg <= datain;
                    end
                    if (memExit) begin
                        pcReg <= (isBranch && condReg) ? PCW'(aluOutReg) : npcReg;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Register file write-back ----------------
    logic          wrEn;
    logic [RW-1:0] wrIdx;
    logic [DW-1:0] wrData;

    always_comb begin
        wrEn   = 1'b0;
        wrIdx  = src2;
        wrData = aluOutReg;
        if (stateReg == ST_WB) begin
            unique case (opcode)
                OP_ALU: begin
                    wrEn  = 1'b1;
                    wrIdx = dstR;
                end
                OP_ADDI, OP_SUBI: wrEn = 1'b1;
                OP_LW: begin
                    wrEn   = 1'b1;
                    wrData = lmdReg;
                end
                default: ;
            endcase
        end
        // Writes to R0 are silently dropped.
        if (wrIdx == '0) begin
            wrEn = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
        end else if (wrEn) begin
            regFile[wrIdx] <= wrData;
        end
    end

    assign pc       = pcReg;
    assign mem_addr = aluOutReg;
    assign dataout  = bReg;

endmodule

// File: tb/tb_vsa_param_core.sv
// Scoreboard bench for vsa_param_core (default parameters: DW=8, NREG=4,
// PCW=6, PC_STEP=2, so IW=12, IMMW=5). The driver pushes the expected
// retire (pc, cycle) and data-memory accesses; two monitors pop and compare
// whenever the DUT retires or requests memory.
module tb_vsa_param_core;

    typedef struct {
        logic [5:0] pc;
        int         cyc;
    } retRec_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } memRec_t;

    logic        clock       = 1'b0;
    logic        reset_n     = 1'b1;
    logic        inst_valid  = 1'b0;
    logic [11:0] instruction = '0;
    logic [7:0]  datain      = '0;
    logic        mem_ack     = 1'b0;
    logic [5:0]  pc;
    logic        mem_req;
    logic        wr;
    logic [7:0]  mem_addr;
    logic [7:0]  dataout;
    logic        halted;
    logic        retire;

    int errors    = 0;
    int checks    = 0;
    int cycleCnt  = 0;
    int memWaits  = 0;
    int waitCnt   = 0;
    int reqCycles = 0;
    bit armed     = 1'b0;

    retRec_t retQ[$];
    memRec_t memQ[$];

    vsa_param_core dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc          (pc),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .mem_req     (mem_req),
        .wr          (wr),
        .mem_addr    (mem_addr),
        .dataout     (dataout),
        .datain      (datain),
        .mem_ack     (mem_ack),
        .halted      (halted),
        .retire      (retire)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder + memory scoreboard monitor (one block so the ack it
    // drives and the check it makes see the same decision).
    always @(negedge clock) begin
        if (armed && reset_n && mem_req) begin
            mem_ack = (waitCnt >= memWaits);
            waitCnt++;
            reqCycles++;
            if (memQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: mem_req=1 addr=%0h, no access expected", mem_addr);
            end else begin
                chk("mem_wr", 32'(wr), 32'(memQ[0].wr));
                chk("mem_addr", 32'(mem_addr), 32'(memQ[0].addr));
                if (memQ[0].wr) chk("mem_dataout", 32'(dataout), 32'(memQ[0].data));
                if (mem_ack) begin
                    chk("mem_req_cycles", 32'(reqCycles), 32'(memQ[0].cyc));
                    void'(memQ.pop_front());
                end
            end
        end else begin
            mem_ack   = 1'b0;
            waitCnt   = 0;
            reqCycles = 0;
        end
    end

    // Retire scoreboard monitor.
    always @(negedge clock) begin
        if (armed && reset_n && retire) begin
            if (retQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: retire=1 at pc=%0d, none expected", pc);
            end else begin
                retRec_t r;
                r = retQ.pop_front();
                chk("retire_pc", 32'(pc), 32'(r.pc));
                chk("retire_cycle", 32'(cycleCnt), 32'(r.cyc));
            end
        end
    end

    task automatic expectMem(input logic w, input logic [7:0] a, input logic [7:0] d, input int cyc);
        memRec_t m;
        m.wr = w; m.addr = a; m.data = d; m.cyc = cyc;
        memQ.push_back(m);
    endtask

    // Called at a negedge of an IF cycle; returns at the negedge of the next IF cycle.
    task automatic runInstr(input logic [11:0] instr, input logic [5:0] curPc, input int stall,
                            input int waits, input int lat, input logic [5:0] expPc);
        retRec_t r;
        bit      done;
        chk("pc_at_fetch", 32'(pc), 32'(curPc));
        memWaits = waits;
        r.pc  = expPc;
        r.cyc = cycleCnt + lat - 1;
        retQ.push_back(r);
        instruction = instr;
        inst_valid  = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk("pc_held_in_stall", 32'(pc), 32'(curPc));
        end
        inst_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (retire) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL retire_timeout: instr %03h at pc %0d never retired", instr, curPc);
        end
        inst_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic applyReset();
        retQ.delete();
        memQ.delete();
        @(negedge clock);
        reset_n    = 1'b0;
        inst_valid = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_retire", 32'(retire), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_wr", 32'(wr), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_dataout", 32'(dataout), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        applyReset();
        armed = 1'b1;

        // ---- Phase A: ALU/immediate ops, loads/stores, fetch stall, halt ----
        runInstr(12'h825, 6'd0, 0, 0, 5, 6'd2);           // ADDI R1=R0+5
        expectMem(1'b1, 8'h01, 8'h05, 1);
        runInstr(12'h221, 6'd2, 0, 0, 5, 6'd4);           // SW R1 -> [R0+1]
        runInstr(12'hAA1, 6'd4, 3, 0, 8, 6'd6);           // SUBI R1=R1-1 (4), 3-cycle fetch stall
        datain = 8'hA5;
        expectMem(1'b0, 8'h07, 8'h00, 3);
        runInstr(12'h0C3, 6'd6, 0, 2, 7, 6'd8);           // LW R2=[R1+3], 2 wait cycles
        runInstr(12'hA61, 6'd8, 0, 0, 5, 6'd10);          // SUBI R3=R0-1 (FF)
        expectMem(1'b1, 8'hFF, 8'hA5, 1);
        runInstr(12'h3C0, 6'd10, 0, 0, 5, 6'd12);         // SW R2 -> [R3+0]
        runInstr(12'h769, 6'd12, 0, 0, 5, 6'd14);         // SUB R1=R2-R3 (A6)
        runInstr(12'h71F, 6'd14, 0, 0, 5, 6'd16);         // SRA R3=R2>>>1 (D2)
        runInstr(12'h68D, 6'd16, 0, 0, 5, 6'd18);         // NOT R1=~R1 (59)
        expectMem(1'b1, 8'hD4, 8'h59, 2);
        runInstr(12'h3A2, 6'd18, 0, 1, 6, 6'd20);         // SW R1 -> [R3+2], 1 wait

        // HALT at pc 20: halted in cycle 3, then frozen.
        chk("halt_pc_at_fetch", 32'(pc), 32'd20);
        instruction = 12'hE00;
        inst_valid  = 1'b1;
        @(negedge clock);
        inst_valid = 1'b0;
        chk("halt_cycle2_not_halted", 32'(halted), 32'h0);
        @(negedge clock);
        chk("halt_cycle3_halted", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            inst_valid = 1'b1;
            @(negedge clock);
            chk("halt_hold", 32'(halted), 32'h1);
            chk("halt_pc_frozen", 32'(pc), 32'd20);
            chk("halt_no_mem_req", 32'(mem_req), 32'h0);
        end
        inst_valid = 1'b0;

        // ---- Phase B: branches, R0 write drop, PC wrap ----
        applyReset();
        runInstr(12'h85E, 6'd0, 0, 0, 5, 6'd2);           // ADDI R2=R0+30
        runInstr(12'h750, 6'd2, 0, 0, 5, 6'd4);           // ADD R2=R2+R2 (3C)
        expectMem(1'b1, 8'h00, 8'h3C, 1);
        runInstr(12'h2C0, 6'd4, 0, 0, 5, 6'd6);           // SW R2 -> [R1+0]
        runInstr(12'h863, 6'd6, 0, 0, 5, 6'd8);           // ADDI R3=R0+3
        runInstr(12'h77C, 6'd8, 0, 0, 5, 6'd10);          // XOR R3=R2^R3 (3F)
        runInstr(12'h49E, 6'd10, 0, 0, 5, 6'd8);          // BEQZ R1,-2: taken back to 8
        runInstr(12'hC9E, 6'd8, 0, 0, 5, 6'd10);          // BNEZ R1,-2: not taken
        runInstr(12'hD83, 6'd10, 0, 0, 5, 6'd18);         // BNEZ R3,+3: taken to 18
        expectMem(1'b1, 8'h3D, 8'h3F, 1);
        runInstr(12'h361, 6'd18, 0, 0, 5, 6'd20);         // SW R3 -> [R2+1]
        runInstr(12'h807, 6'd20, 0, 0, 5, 6'd22);         // ADDI R0=R0+7 (dropped)
        expectMem(1'b1, 8'h09, 8'h00, 1);
        runInstr(12'h209, 6'd22, 0, 0, 5, 6'd24);         // SW R0 -> [R0+9]
        runInstr(12'h598, 6'd24, 0, 0, 5, 6'd26);         // BEQZ R3,-8: not taken
        runInstr(12'hD90, 6'd26, 0, 0, 5, 6'd60);         // BNEZ R3,-16: 28-32 wraps to 60
        expectMem(1'b1, 8'h3F, 8'h3C, 1);
        runInstr(12'h3C0, 6'd60, 0, 0, 5, 6'd62);         // SW R2 -> [R3+0]

        // ---- Phase C: asynchronous reset during a stalled store ----
        applyReset();
        chk("rmem_pc_at_fetch", 32'(pc), 32'h0);
        expectMem(1'b1, 8'h02, 8'h00, 99);
        memWaits    = 50;
        instruction = 12'h202;                            // SW R0 -> [R0+2]
        inst_valid  = 1'b1;
        @(negedge clock);                                 // cycle 2 (ID)
        inst_valid = 1'b0;
        @(negedge clock);                                 // cycle 3 (EX)
        @(negedge clock);                                 // cycle 4 (MEM)
        chk("rmem_req_before", 32'(mem_req), 32'h1);
        chk("rmem_wr_before", 32'(wr), 32'h1);
        @(negedge clock);                                 // cycle 5 (still stalled)
        chk("rmem_req_stalled", 32'(mem_req), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmem_req_dropped", 32'(mem_req), 32'h0);
        chk("rmem_wr_dropped", 32'(wr), 32'h0);
        chk("rmem_pc_zero", 32'(pc), 32'h0);
        chk("rmem_addr_zero", 32'(mem_addr), 32'h0);
        memQ.delete();
        retQ.delete();
        memWaits = 0;
        @(negedge clock);
        reset_n = 1'b1;
        runInstr(12'h825, 6'd0, 0, 0, 5, 6'd2);           // ADDI R1=R0+5
        expectMem(1'b1, 8'h01, 8'h05, 1);
        runInstr(12'h221, 6'd2, 0, 0, 5, 6'd4);           // SW R1 -> [R0+1]

        chk("retire_queue_drained", 32'(retQ.size()), 32'h0);
        chk("mem_queue_drained", 32'(memQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
